// File: rtl/piece_queue.sv
// Piece preview queue: a DEPTH-entry FIFO of tetromino types fed from an upstream LFSR word.
// Define PIECE_QUEUE_BAG7_EN to add the 7-bag randomizer, which rejects types already used in the current bag.
module piece_queue #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] rnd,
  input  logic       take,
  output logic [2:0] piece,
  output logic       valid,
  output logic [2:0] next_piece,
  output logic       next_valid,
  output logic [3:0] count
);

  localparam logic [3:0] DEPTH_C = 4'(DEPTH);

  typedef enum logic {FILL, FULL} state_e;

  state_e     state_q;
  logic [2:0] slot_q [DEPTH];
  logic [2:0] slot_d [DEPTH];
  logic [3:0] count_q, count_d, wr_idx;
  logic [2:0] piece_q, next_piece_q;
  logic       valid_q, next_valid_q;
  logic [2:0] cand;
  logic       accept, pop, push;
  logic       unused_rnd;

  assign cand       = rnd[2:0];
  assign unused_rnd = ^rnd[9:3];

`ifdef PIECE_QUEUE_BAG7_EN
  logic [6:0] mask_q, mask_d, mask_set;
  logic [7:0] reject_vec;

  // Type 7 is folded into the lookup as a permanently "used" entry.
  assign reject_vec = {1'b1, mask_q};
  assign accept     = !reject_vec[cand];
  assign mask_set   = mask_q | (7'd1 << cand);

  always_comb begin
    mask_d = mask_q;
    if (push) mask_d = (mask_set == 7'h7F) ? 7'd0 : mask_set;
  end
`else
  assign accept = (cand != 3'd7);
`endif

  assign pop  = take && valid_q;
  assign push = accept && ((state_q == FILL) || pop);

  always_comb begin
    slot_d = slot_q;
    if (pop) begin
      for (int i = 0; i < DEPTH - 1; i++) slot_d[i] = slot_q[i+1];
      slot_d[DEPTH-1] = 3'd0;
    end
    wr_idx = count_q - {3'd0, pop};
    if (push) begin
      for (int i = 0; i < DEPTH; i++)
        if (4'(i) == wr_idx) slot_d[i] = cand;
    end
    count_d = count_q + {3'd0, push} - {3'd0, pop};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= FILL;
      count_q      <= 4'd0;
      piece_q      <= 3'd0;
      next_piece_q <= 3'd0;
      valid_q      <= 1'b0;
      next_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) slot_q[i] <= 3'd0;
`ifdef PIECE_QUEUE_BAG7_EN
      mask_q       <= 7'd0;
`endif
    end else begin
      count_q      <= count_d;
      slot_q       <= slot_d;
      valid_q      <= (count_d != 4'd0);
      next_valid_q <= (count_d >= 4'd2);
      piece_q      <= (count_d != 4'd0) ? slot_d[0] : 3'd0;
      next_piece_q <= (count_d >= 4'd2) ? slot_d[1] : 3'd0;
`ifdef PIECE_QUEUE_BAG7_EN
      mask_q       <= mask_d;
`endif
      case (state_q)
        FILL: if (count_d == DEPTH_C) state_q <= FULL;
        FULL: if (pop && !push)       state_q <= FILL;
        default:                      state_q <= FILL;
      endcase
    end
  end

  assign piece      = piece_q;
  assign valid      = valid_q;
  assign next_piece = next_piece_q;
  assign next_valid = next_valid_q;
  assign count      = count_q;

endmodule

// File: tb/tb_piece_queue.sv
// Self-checking bench for piece_queue: queue-based reference model, directed literal checks, then random traffic.
// Honours PIECE_QUEUE_BAG7_EN the same way as the design (bag build runs at DEPTH 8).
module tb_piece_queue;
`ifdef PIECE_QUEUE_BAG7_EN
  localparam int DEPTH = 8;
`else
  localparam int DEPTH = 4;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] rnd;
  logic       take;
  logic [2:0] piece, next_piece;
  logic       valid, next_valid;
  logic [3:0] count;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  int   mq[$];
  logic [6:0] mmask;
  int   push_hist[$];

  piece_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .rnd(rnd), .take(take),
    .piece(piece), .valid(valid), .next_piece(next_piece),
    .next_valid(next_valid), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of piece types updated by the queue's rules on each edge.
  always @(posedge clk) begin
    int c;
    bit pop, acc, psh;
    if (reset) begin
      mq.delete();
      push_hist.delete();
      mmask = 7'd0;
    end else begin
      c   = int'(rnd[2:0]);
      pop = take && (mq.size() > 0);
      acc = (c != 7);
`ifdef PIECE_QUEUE_BAG7_EN
      if (acc && mmask[c]) acc = 1'b0;
`endif
      psh = acc && ((mq.size() < DEPTH) || pop);
      if (pop) void'(mq.pop_front());
      if (psh) begin
        mq.push_back(c);
        push_hist.push_back(c);
`ifdef PIECE_QUEUE_BAG7_EN
        mmask[c] = 1'b1;
        if (mmask == 7'h7F) mmask = 7'd0;
`endif
      end
    end
  end

  // Compare process: outputs against the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (check_en) begin
      chk("count", int'(count), mq.size());
      chk("valid", int'(valid), int'(mq.size() > 0));
      chk("piece", int'(piece), (mq.size() > 0) ? mq[0] : 0);
      chk("next_valid", int'(next_valid), int'(mq.size() > 1));
      chk("next_piece", int'(next_piece), (mq.size() > 1) ? mq[1] : 0);
    end
  end

  task automatic step(input logic r, input logic [9:0] w, input logic t);
    reset = r; rnd = w; take = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; rnd = 10'h3FF; take = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_en = 1'b1;
    step(1'b1, 10'h3FF, 1'b0);
    chk("rst_count", int'(count), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_piece", int'(piece), 0);

`ifndef PIECE_QUEUE_BAG7_EN
    for (int i = 1; i <= 4; i++) begin
      step(1'b0, 10'h005, 1'b0);
      chk("fill_count", int'(count), i);
      chk("fill_piece", int'(piece), 5);
    end
    step(1'b0, 10'h005, 1'b0);
    chk("full_drop_count", int'(count), 4);
    step(1'b0, 10'h003, 1'b1);
    chk("full_poppush_count", int'(count), 4);
    chk("full_poppush_head", int'(piece), 5);
    for (int i = 0; i < 3; i++) step(1'b0, 10'h007, 1'b1);
    chk("drain_piece", int'(piece), 3);
    chk("drain_count", int'(count), 1);
    step(1'b0, 10'h007, 1'b1);
    chk("empty_count", int'(count), 0);
    step(1'b0, 10'h007, 1'b1);
    chk("underflow_count", int'(count), 0);
    chk("underflow_valid", int'(valid), 0);
    for (int i = 0; i < 5; i++) step(1'b0, 10'h3FF, 1'b0);
    chk("reject7_count", int'(count), 0);
    for (int i = 0; i < 4; i++) step(1'b0, 10'h001, 1'b0);
    chk("refill_count", int'(count), 4);
    step(1'b1, 10'h001, 1'b1);
    chk("rst_full_count", int'(count), 0);
    chk("rst_full_valid", int'(valid), 0);
    step(1'b0, 10'h006, 1'b0);
    chk("first_push_count", int'(count), 1);
    chk("first_push_piece", int'(piece), 6);
`else
    for (int i = 0; i < 10; i++) step(1'b0, 10'h002, 1'b0);
    chk("bag_const_count", int'(count), 1);
    chk("bag_const_piece", int'(piece), 2);
    for (int c = 0; c < 7; c++) step(1'b0, 10'(c), 1'b0);
    chk("bag_sweep_count", int'(count), 7);
    chk("bag_sweep_next", int'(next_piece), 0);
    step(1'b0, 10'h002, 1'b0);
    chk("bag_reopen_count", int'(count), 8);
    step(1'b1, 10'h002, 1'b1);
    chk("bag_rst_count", int'(count), 0);
    chk("bag_rst_valid", int'(valid), 0);
    step(1'b0, 10'h002, 1'b0);
    chk("bag_rst_mask_count", int'(count), 1);
    chk("bag_rst_mask_piece", int'(piece), 2);
`endif

    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) == 0), 10'($urandom), ($urandom_range(0, 2) == 0));
`ifdef PIECE_QUEUE_BAG7_EN
      if (push_hist.size() == 7) begin
        logic [6:0] seen;
        seen = 7'd0;
        foreach (push_hist[k]) seen[push_hist[k]] = 1'b1;
        chk("bag_complete", int'(seen), 127);
        push_hist.delete();
      end
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/piece_queue.md
PIECE_QUEUE -- requirements
Module: piece_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, number of queue entries (legal 2..8).
REQ-002 SHALL have port clk, input, 1, single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port rnd, input, 10, free-running pseudo-random word from the upstream LFSR_10 generator.
REQ-005 SHALL have port take, input, 1, consumer request to pop the head piece.
REQ-006 SHALL have port piece, output, 3, head piece type 0..6.
REQ-007 SHALL have port valid, output, 1, high when piece holds a real entry.
REQ-008 SHALL have port next_piece, output, 3, second entry (preview).
REQ-009 SHALL have port next_valid, output, 1, high when count >= 2.
REQ-010 SHALL have port count, output, 4, number of occupied entries 0..DEPTH.

Function
REQ-011 SHALL form candidate c = rnd[2:0] every cycle.
REQ-012 SHALL treat c = 7 as rejected: no push that cycle.
REQ-013 SHALL push an accepted candidate at the tail on the clock edge when (count < DEPTH) or (take && valid).
REQ-014 SHALL pop the head on the clock edge when take && valid; take with valid = 0 SHALL be ignored.
REQ-015 SHALL allow pop and push on the same edge when full; count SHALL then stay DEPTH and the new entry SHALL land at the tail.
REQ-016 SHALL never let count exceed DEPTH; when full without take, the candidate SHALL be dropped.
REQ-017 SHALL drive piece, next_piece, valid, next_valid and count from registers only; a push becomes visible the cycle after the edge (1-cycle latency).
REQ-018 SHALL keep FIFO order; entries shift toward the head on pop with no bubbles.
REQ-019 SHALL hold piece and next_piece at 0 while their valid flags are low.
REQ-020 SHALL use a two-state controller: FILL (count < DEPTH, accepting pushes) and FULL (count == DEPTH, pushes only alongside a pop). FILL->FULL when a push makes count = DEPTH; FULL->FILL on a pop without a push.

Reset
REQ-021 SHALL on reset clear count to 0, set valid = 0, next_valid = 0, piece = 0 and next_piece = 0, enter state FILL and clear the bag mask.
REQ-022 SHALL give reset priority over take and push on the same edge, including mid-operation with a full queue.
REQ-023 SHALL accept its first push on the first edge after reset deasserts.

Configuration
REQ-024 SHALL compile a 7-bag randomizer when macro PIECE_QUEUE_BAG7_EN is defined.
REQ-025 With PIECE_QUEUE_BAG7_EN: keep a 7-bit used mask; candidate c SHALL also be rejected when mask[c] = 1; on push set mask[c].
REQ-026 With PIECE_QUEUE_BAG7_EN: when a push sets the last clear mask bit, the mask SHALL become all-zero on that same edge.
REQ-027 With PIECE_QUEUE_BAG7_EN: every 7 consecutive pushes after reset SHALL contain each type 0..6 exactly once.
REQ-028 Without PIECE_QUEUE_BAG7_EN: no mask logic; only the c = 7 rejection applies.

Verification
REQ-029 Reset, then rnd = 10'h005 held for 4 cycles, take = 0 -> count steps 1,2,3,4; piece = 5, valid = 1 from the cycle after the first edge; state FULL (no bag).
REQ-030 Empty queue, rnd = 10'h3FF (c = 7) for 5 cycles -> count stays 0, valid = 0.
REQ-031 Full queue holding 5,5,5,5; take = 1 with rnd = 10'h003 for one edge -> count = 4, head = 5, tail = 3; after 3 more pops with rnd = 7 -> piece = 3, count = 1.
REQ-032 take = 1 with count = 0 and rnd = 7 -> count stays 0, no underflow, outputs unchanged.
REQ-033 PIECE_QUEUE_BAG7_EN, DEPTH = 8, rnd[2:0] = 2 constant for 10 cycles -> exactly one push (2); then sweep c = 0..6 -> pushes 0,1,3,4,5,6; mask clears after the 7th push, and c = 2 is accepted again next.
REQ-034 Full queue, reset = 1 together with take = 1 -> next cycle count = 0, valid = 0, mask clear.
